// File: rtl/regbank_requester_if.sv
// Bundle of the command, response and register-bank signals around
// regbank_requester. The master view is the requester itself (it masters the
// bank and serves the decode stage); the slave view is everything around it.
interface regbank_requester_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    // command port from decode
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr_en;
    logic [ADDR_W-1:0] cmd_wr_addr;
    logic [DATA_W-1:0] cmd_wr_data;
    logic              cmd_rd_a_en;
    logic [ADDR_W-1:0] cmd_rd_a_addr;
    logic              cmd_rd_b_en;
    logic [ADDR_W-1:0] cmd_rd_b_addr;

    // response port
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_a;
    logic [DATA_W-1:0] rsp_b;

    // toggle-trigger register bank port
    logic [ADDR_W-1:0] bank_addr;
    logic              bank_rw;
    logic [DATA_W-1:0] bank_data_in;
    logic              bank_trigger;
    logic [DATA_W-1:0] bank_data_out;

    modport master (
        input  cmd_valid, cmd_wr_en, cmd_wr_addr, cmd_wr_data,
        input  cmd_rd_a_en, cmd_rd_a_addr, cmd_rd_b_en, cmd_rd_b_addr,
        input  rsp_ready, bank_data_out,
        output cmd_ready, rsp_valid, rsp_a, rsp_b,
        output bank_addr, bank_rw, bank_data_in, bank_trigger
    );

    modport slave (
        output cmd_valid, cmd_wr_en, cmd_wr_addr, cmd_wr_data,
        output cmd_rd_a_en, cmd_rd_a_addr, cmd_rd_b_en, cmd_rd_b_addr,
        output rsp_ready, bank_data_out,
        input  cmd_ready, rsp_valid, rsp_a, rsp_b,
        input  bank_addr, bank_rw, bank_data_in, bank_trigger
    );
endinterface

// File: rtl/regbank_requester.sv
// regbank_requester: accepts one operand-access command (optional write-back,
// then up to two operand reads), sequences each access over the register
// bank's toggle-trigger port and returns both read results on a valid/ready
// response. Accesses run strictly write, read A, read B so that a read of the
// register being written sees the new value.
module regbank_requester #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regbank_requester_if.master  io
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // which access is currently presented to the bank
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WR   = 2'd1,
        OP_RA   = 2'd2,
        OP_RB   = 2'd3
    } op_e;

    // counter value that marks the final WAIT edge
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    // first access still to do; bit 2 = write, bit 1 = read A, bit 0 = read B
    function automatic op_e pick_op(input logic [2:0] pend);
        op_e op;
        if (pend[2]) begin
            op = OP_WR;
        end else if (pend[1]) begin
            op = OP_RA;
        end else if (pend[0]) begin
            op = OP_RB;
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

    // pending-flag bit owned by an access
    function automatic logic [2:0] op_mask(input op_e op);
        logic [2:0] m;
        case (op)
            OP_WR:   m = 3'b100;
            OP_RA:   m = 3'b010;
            OP_RB:   m = 3'b001;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    state_e            state_r,        state_nxt_s;
    logic [3:0]        cnt_r,          cnt_nxt_s;
    op_e               cur_op_r,       cur_op_nxt_s;
    logic [2:0]        pend_r,         pend_nxt_s;
    logic [ADDR_W-1:0] wr_addr_r,      wr_addr_nxt_s;
    logic [DATA_W-1:0] wr_data_r,      wr_data_nxt_s;
    logic [ADDR_W-1:0] ra_addr_r,      ra_addr_nxt_s;
    logic [ADDR_W-1:0] rb_addr_r,      rb_addr_nxt_s;
    logic [ADDR_W-1:0] bank_addr_r,    bank_addr_nxt_s;
    logic              bank_rw_r,      bank_rw_nxt_s;
    logic [DATA_W-1:0] bank_data_in_r, bank_data_in_nxt_s;
    logic              bank_trig_r,    bank_trig_nxt_s;
    logic [DATA_W-1:0] rsp_a_r,        rsp_a_nxt_s;
    logic [DATA_W-1:0] rsp_b_r,        rsp_b_nxt_s;
    logic              rsp_valid_r,    rsp_valid_nxt_s;

    logic              cmd_ready_s;
    logic              launch_s;
    logic [2:0]        launch_pend_s;
    op_e               launch_op_s;
    logic [ADDR_W-1:0] src_wr_addr_s;
    logic [DATA_W-1:0] src_wr_data_s;
    logic [ADDR_W-1:0] src_ra_addr_s;
    logic [ADDR_W-1:0] src_rb_addr_s;

    assign cmd_ready_s = (state_r == ST_IDLE) && !rsp_valid_r;

    // The first access is launched on the accept edge straight from the
    // command inputs; later accesses come from the captured command copy.
    assign src_wr_addr_s = (state_r == ST_IDLE) ? io.cmd_wr_addr   : wr_addr_r;
    assign src_wr_data_s = (state_r == ST_IDLE) ? io.cmd_wr_data   : wr_data_r;
    assign src_ra_addr_s = (state_r == ST_IDLE) ? io.cmd_rd_a_addr : ra_addr_r;
    assign src_rb_addr_s = (state_r == ST_IDLE) ? io.cmd_rd_b_addr : rb_addr_r;

    assign io.cmd_ready    = cmd_ready_s;
    assign io.rsp_valid    = rsp_valid_r;
    assign io.rsp_a        = rsp_a_r;
    assign io.rsp_b        = rsp_b_r;
    assign io.bank_addr    = bank_addr_r;
    assign io.bank_rw      = bank_rw_r;
    assign io.bank_data_in = bank_data_in_r;
    assign io.bank_trigger = bank_trig_r;

    // Next-state and next-output decode for the access sequencer.
    always_comb begin
        state_nxt_s        = state_r;
        cnt_nxt_s          = cnt_r;
        cur_op_nxt_s       = cur_op_r;
        pend_nxt_s         = pend_r;
        wr_addr_nxt_s      = wr_addr_r;
        wr_data_nxt_s      = wr_data_r;
        ra_addr_nxt_s      = ra_addr_r;
        rb_addr_nxt_s      = rb_addr_r;
        bank_addr_nxt_s    = bank_addr_r;
        bank_rw_nxt_s      = bank_rw_r;
        bank_data_in_nxt_s = bank_data_in_r;
        bank_trig_nxt_s    = bank_trig_r;
        rsp_a_nxt_s        = rsp_a_r;
        rsp_b_nxt_s        = rsp_b_r;
        rsp_valid_nxt_s    = rsp_valid_r;
        launch_s           = 1'b0;
        launch_pend_s      = 3'b000;
        launch_op_s        = OP_NONE;

        case (state_r)
            ST_IDLE: begin
                if (io.cmd_valid && cmd_ready_s) begin
                    wr_addr_nxt_s = io.cmd_wr_addr;
                    wr_data_nxt_s = io.cmd_wr_data;
                    ra_addr_nxt_s = io.cmd_rd_a_addr;
                    rb_addr_nxt_s = io.cmd_rd_b_addr;
                    // results of disabled reads must read back as zero
                    rsp_a_nxt_s   = {DATA_W{1'b0}};
                    rsp_b_nxt_s   = {DATA_W{1'b0}};
                    launch_s      = 1'b1;
                    launch_pend_s = {io.cmd_wr_en, io.cmd_rd_a_en, io.cmd_rd_b_en};
                    state_nxt_s   = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (cur_op_r == OP_NONE) begin
                    // empty command: answer without touching the bank
                    rsp_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_RESP;
                end else begin
                    bank_trig_nxt_s = ~bank_trig_r;
                    cnt_nxt_s       = SETTLE_LAST;
                    state_nxt_s     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_r != 4'd0) begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end else begin
                    case (cur_op_r)
                        OP_RA:   rsp_a_nxt_s   = io.bank_data_out;
                        OP_RB:   rsp_b_nxt_s   = io.bank_data_out;
                        OP_WR:   bank_rw_nxt_s = 1'b1;
                        default: bank_rw_nxt_s = bank_rw_r;
                    endcase
                    if (pend_r != 3'b000) begin
                        launch_s      = 1'b1;
                        launch_pend_s = pend_r;
                        state_nxt_s   = ST_SETUP;
                    end else begin
                        cur_op_nxt_s    = OP_NONE;
                        rsp_valid_nxt_s = 1'b1;
                        state_nxt_s     = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                if (io.rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Present the next access to the bank one SETUP cycle before its toggle.
        if (launch_s) begin
            launch_op_s  = pick_op(launch_pend_s);
            cur_op_nxt_s = launch_op_s;
            pend_nxt_s   = launch_pend_s & ~op_mask(launch_op_s);
            case (launch_op_s)
                OP_WR: begin
                    bank_addr_nxt_s    = src_wr_addr_s;
                    bank_rw_nxt_s      = 1'b0;
                    bank_data_in_nxt_s = src_wr_data_s;
                end
                OP_RA: begin
                    bank_addr_nxt_s = src_ra_addr_s;
                    bank_rw_nxt_s   = 1'b1;
                end
                OP_RB: begin
                    bank_addr_nxt_s = src_rb_addr_s;
                    bank_rw_nxt_s   = 1'b1;
                end
                default: begin
                    bank_rw_nxt_s = 1'b1;
                end
            endcase
        end else begin
            launch_op_s = OP_NONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers; reset leaves the bank port on a read so
    // the trigger drop it causes can never be taken as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r          <= 4'd0;
            cur_op_r       <= OP_NONE;
            pend_r         <= 3'b000;
            wr_addr_r      <= {ADDR_W{1'b0}};
            wr_data_r      <= {DATA_W{1'b0}};
            ra_addr_r      <= {ADDR_W{1'b0}};
            rb_addr_r      <= {ADDR_W{1'b0}};
            bank_addr_r    <= {ADDR_W{1'b0}};
            bank_rw_r      <= 1'b1;
            bank_data_in_r <= {DATA_W{1'b0}};
            bank_trig_r    <= 1'b0;
            rsp_a_r        <= {DATA_W{1'b0}};
            rsp_b_r        <= {DATA_W{1'b0}};
            rsp_valid_r    <= 1'b0;
        end else begin
            cnt_r          <= cnt_nxt_s;
            cur_op_r       <= cur_op_nxt_s;
            pend_r         <= pend_nxt_s;
            wr_addr_r      <= wr_addr_nxt_s;
            wr_data_r      <= wr_data_nxt_s;
            ra_addr_r      <= ra_addr_nxt_s;
            rb_addr_r      <= rb_addr_nxt_s;
            bank_addr_r    <= bank_addr_nxt_s;
            bank_rw_r      <= bank_rw_nxt_s;
            bank_data_in_r <= bank_data_in_nxt_s;
            bank_trig_r    <= bank_trig_nxt_s;
            rsp_a_r        <= rsp_a_nxt_s;
            rsp_b_r        <= rsp_b_nxt_s;
            rsp_valid_r    <= rsp_valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_regbank_requester.sv
// Directed bench for regbank_requester: two instances (settle 4 and settle 1)
// each driving a behavioural toggle-trigger register bank.
module tb_regbank_requester;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    localparam logic [31:0] PRELOAD [16] = '{
        32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
        32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
    localparam logic [31:0] B2B_A [3] = '{32'hA5A5_0004, 32'd1, 32'd0};
    localparam logic [31:0] B2B_B [3] = '{32'd0, 32'hA5A5_0004, 32'h0000_0077};

    regbank_requester_if #(.DATA_W(32), .ADDR_W(4)) bi0 ();
    regbank_requester_if #(.DATA_W(32), .ADDR_W(4)) bi1 ();

    regbank_requester #(.DATA_W(32), .ADDR_W(4), .SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .io(bi0));
    regbank_requester #(.DATA_W(32), .ADDR_W(4), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .io(bi1));

    always #5 clk = ~clk;

    // cycle number of the most recent rising edge
    always @(posedge clk) cyc = cyc + 1;

    // behavioural banks with a log of every trigger toggle
    logic [31:0] mem0 [16] = PRELOAD;
    logic [31:0] mem1 [16] = PRELOAD;
    int          tg0_n = 0;
    int          tg1_n = 0;
    int          tg0_cyc [64];
    logic        tg0_rw  [64];
    logic [3:0]  tg0_addr[64];
    logic [31:0] tg0_data[64];
    int          tg1_cyc [64];

    always @(posedge bi0.bank_trigger or negedge bi0.bank_trigger) begin
        if (tg0_n < 64) begin
            tg0_cyc[tg0_n]  <= cyc;
            tg0_rw[tg0_n]   <= bi0.bank_rw;
            tg0_addr[tg0_n] <= bi0.bank_addr;
            tg0_data[tg0_n] <= bi0.bank_data_in;
        end
        tg0_n <= tg0_n + 1;
        if (!bi0.bank_rw) begin
            mem0[bi0.bank_addr] <= bi0.bank_data_in;
            bi0.bank_data_out   <= bi0.bank_data_in;
        end else begin
            bi0.bank_data_out <= mem0[bi0.bank_addr];
        end
    end

    always @(posedge bi1.bank_trigger or negedge bi1.bank_trigger) begin
        if (tg1_n < 64) tg1_cyc[tg1_n] <= cyc;
        tg1_n <= tg1_n + 1;
        if (!bi1.bank_rw) begin
            mem1[bi1.bank_addr] <= bi1.bank_data_in;
            bi1.bank_data_out   <= bi1.bank_data_in;
        end else begin
            bi1.bank_data_out <= mem1[bi1.bank_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // present a command to dut0, return the accept edge number
    task automatic send0(input logic wr, input logic [3:0] wa, input logic [31:0] wd,
                         input logic ra, input logic [3:0] aa,
                         input logic rb, input logic [3:0] ba, output int e0);
        bi0.cmd_wr_en = wr; bi0.cmd_wr_addr = wa; bi0.cmd_wr_data = wd;
        bi0.cmd_rd_a_en = ra; bi0.cmd_rd_a_addr = aa;
        bi0.cmd_rd_b_en = rb; bi0.cmd_rd_b_addr = ba;
        bi0.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bi0.cmd_ready; i++) @(negedge clk);
        check_eq("accept_ready", 32'(bi0.cmd_ready), 32'd1);
        e0 = cyc + 1;
        @(negedge clk);
        // later command changes must be ignored
        bi0.cmd_valid = 1'b0;
        bi0.cmd_wr_en = ~wr; bi0.cmd_wr_addr = ~wa; bi0.cmd_wr_data = ~wd;
        bi0.cmd_rd_a_en = ~ra; bi0.cmd_rd_a_addr = ~aa;
        bi0.cmd_rd_b_en = ~rb; bi0.cmd_rd_b_addr = ~ba;
    endtask

    task automatic wait_rsp0(output int t);
        for (int i = 0; i < 200 && !bi0.rsp_valid; i++) @(negedge clk);
        check_eq("rsp_arrives", 32'(bi0.rsp_valid), 32'd1);
        t = cyc;
    endtask

    task automatic take0();
        bi0.rsp_ready = 1'b1;
        @(negedge clk);
        bi0.rsp_ready = 1'b0;
        check_eq("rsp_taken", 32'(bi0.rsp_valid), 32'd0);
    endtask

    task automatic drive1(input logic wr, input logic [3:0] wa, input logic [31:0] wd,
                          input logic ra, input logic [3:0] aa,
                          input logic rb, input logic [3:0] ba);
        bi1.cmd_wr_en = wr; bi1.cmd_wr_addr = wa; bi1.cmd_wr_data = wd;
        bi1.cmd_rd_a_en = ra; bi1.cmd_rd_a_addr = aa;
        bi1.cmd_rd_b_en = rb; bi1.cmd_rd_b_addr = ba;
        bi1.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bi1.cmd_ready; i++) @(negedge clk);
        check_eq("b2b_accept", 32'(bi1.cmd_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_cmd_ready"}, 32'(bi0.cmd_ready), 32'd1);
        check_eq({pfx, "_rsp_valid"}, 32'(bi0.rsp_valid), 32'd0);
        check_eq({pfx, "_rsp_a"}, bi0.rsp_a, 32'd0);
        check_eq({pfx, "_rsp_b"}, bi0.rsp_b, 32'd0);
        check_eq({pfx, "_bank_addr"}, 32'(bi0.bank_addr), 32'd0);
        check_eq({pfx, "_bank_rw"}, 32'(bi0.bank_rw), 32'd1);
        check_eq({pfx, "_bank_data_in"}, bi0.bank_data_in, 32'd0);
        check_eq({pfx, "_bank_trigger"}, 32'(bi0.bank_trigger), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, t, base;
        logic stable;
        logic [31:0] ha, hb;

        bi0.cmd_valid = 1'b0; bi0.cmd_wr_en = 1'b0; bi0.cmd_wr_addr = 4'd0;
        bi0.cmd_wr_data = 32'd0; bi0.cmd_rd_a_en = 1'b0; bi0.cmd_rd_a_addr = 4'd0;
        bi0.cmd_rd_b_en = 1'b0; bi0.cmd_rd_b_addr = 4'd0; bi0.rsp_ready = 1'b0;
        bi1.cmd_valid = 1'b0; bi1.cmd_wr_en = 1'b0; bi1.cmd_wr_addr = 4'd0;
        bi1.cmd_wr_data = 32'd0; bi1.cmd_rd_a_en = 1'b0; bi1.cmd_rd_a_addr = 4'd0;
        bi1.cmd_rd_b_en = 1'b0; bi1.cmd_rd_b_addr = 4'd0; bi1.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // read A = R1, read B = R2
        base = tg0_n;
        send0(1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 1'b1, 4'd2, e0);
        wait_rsp0(t);
        check_eq("rd2_latency", t, e0 + 10);
        check_eq("rd2_rsp_a", bi0.rsp_a, 32'd0);
        check_eq("rd2_rsp_b", bi0.rsp_b, 32'd1);
        check_eq("rd2_toggles", tg0_n - base, 32'd2);
        check_eq("rd2_tg0_time", tg0_cyc[base], e0 + 1);
        check_eq("rd2_tg1_time", tg0_cyc[base + 1], e0 + 6);
        check_eq("rd2_tg0_rw", 32'(tg0_rw[base]), 32'd1);
        check_eq("rd2_tg1_rw", 32'(tg0_rw[base + 1]), 32'd1);
        check_eq("rd2_bank_rw", 32'(bi0.bank_rw), 32'd1);
        take0();

        // write R8 = 8 then read A = R8
        base = tg0_n;
        send0(1'b1, 4'd8, 32'd8, 1'b1, 4'd8, 1'b0, 4'd5, e0);
        wait_rsp0(t);
        check_eq("wr_latency", t, e0 + 10);
        check_eq("wr_toggles", tg0_n - base, 32'd2);
        check_eq("wr_tg0_rw", 32'(tg0_rw[base]), 32'd0);
        check_eq("wr_tg0_addr", 32'(tg0_addr[base]), 32'd8);
        check_eq("wr_tg0_data", tg0_data[base], 32'd8);
        check_eq("wr_tg1_rw", 32'(tg0_rw[base + 1]), 32'd1);
        check_eq("wr_rsp_a", bi0.rsp_a, 32'd8);
        check_eq("wr_rsp_b", bi0.rsp_b, 32'd0);
        check_eq("wr_bank_data_in", bi0.bank_data_in, 32'd8);
        take0();

        // full command, response held back 20 cycles
        base = tg0_n;
        send0(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1, 4'd3, 1'b1, 4'd0, e0);
        wait_rsp0(t);
        check_eq("full_latency", t, e0 + 15);
        check_eq("full_toggles", tg0_n - base, 32'd3);
        check_eq("full_rsp_a", bi0.rsp_a, 32'hDEAD_BEEF);
        check_eq("full_rsp_b", bi0.rsp_b, 32'hFFFF_FFFF);
        ha = bi0.rsp_a; hb = bi0.rsp_b; stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bi0.rsp_valid || bi0.rsp_a !== ha || bi0.rsp_b !== hb || bi0.cmd_ready)
                stable = 1'b0;
        end
        check_eq("full_hold", 32'(stable), 32'd1);
        bi0.rsp_ready = 1'b1;
        check_eq("full_ready_before_take", 32'(bi0.cmd_ready), 32'd0);
        @(negedge clk);
        bi0.rsp_ready = 1'b0;
        check_eq("full_rsp_dropped", 32'(bi0.rsp_valid), 32'd0);
        check_eq("full_ready_after_take", 32'(bi0.cmd_ready), 32'd1);

        // command with no enables
        base = tg0_n;
        send0(1'b0, 4'd7, 32'h1111_2222, 1'b0, 4'd3, 1'b0, 4'd3, e0);
        wait_rsp0(t);
        check_eq("none_latency", t, e0 + 1);
        check_eq("none_toggles", tg0_n - base, 32'd0);
        check_eq("none_rsp_a", bi0.rsp_a, 32'd0);
        check_eq("none_rsp_b", bi0.rsp_b, 32'd0);
        take0();

        // single read of R3
        send0(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0, e0);
        wait_rsp0(t);
        check_eq("one_latency", t, e0 + 5);
        check_eq("one_rsp_a", bi0.rsp_a, 32'hDEAD_BEEF);
        check_eq("one_rsp_b", bi0.rsp_b, 32'd0);
        take0();

        // reset during the WAIT of a write
        base = tg0_n;
        send0(1'b1, 4'd5, 32'h1234_5678, 1'b1, 4'd5, 1'b0, 4'd0, e0);
        repeat (2) @(negedge clk);
        check_eq("rst_pre_trigger", 32'(bi0.bank_trigger), 32'd1);
        check_eq("rst_pre_rw", 32'(bi0.bank_rw), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check_eq("midrst_toggles", tg0_n - base, 32'd2);
        check_eq("midrst_drop_rw", 32'(tg0_rw[base + 1]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bi0.rsp_valid) stable = 1'b0;
        end
        check_eq("midrst_no_rsp", 32'(stable), 32'd1);
        check_eq("midrst_quiet", tg0_n - base, 32'd2);
        send0(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 1'b1, 4'd8, e0);
        wait_rsp0(t);
        check_eq("midrst_rd_a", bi0.rsp_a, 32'h1234_5678);
        check_eq("midrst_rd_b", bi0.rsp_b, 32'd8);
        take0();

        // settle 1, back-to-back commands, response always taken
        base = tg1_n;
        bi1.rsp_ready = 1'b1;
        fork
            begin
                drive1(1'b1, 4'd4, 32'hA5A5_0004, 1'b1, 4'd4, 1'b1, 4'd1);
                drive1(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 1'b1, 4'd4);
                drive1(1'b1, 4'd2, 32'h0000_0077, 1'b0, 4'd0, 1'b1, 4'd2);
                bi1.cmd_valid = 1'b0;
            end
            begin
                int k;
                k = 0;
                for (int i = 0; i < 200 && k < 3; i++) begin
                    @(negedge clk);
                    if (bi1.rsp_valid) begin
                        check_eq($sformatf("b2b_rsp_a%0d", k), bi1.rsp_a, B2B_A[k]);
                        check_eq($sformatf("b2b_rsp_b%0d", k), bi1.rsp_b, B2B_B[k]);
                        k++;
                    end
                end
                check_eq("b2b_count", k, 32'd3);
            end
        join
        repeat (3) @(negedge clk);
        check_eq("b2b_toggles", tg1_n - base, 32'd7);
        check_eq("b2b_spacing0", tg1_cyc[base + 1] - tg1_cyc[base], 32'd2);
        check_eq("b2b_spacing1", tg1_cyc[base + 2] - tg1_cyc[base + 1], 32'd2);
        check_eq("b2b_idle", 32'(bi1.rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regbank_requester.md
# regbank_requester

Synchronous initiator for the 16 x 32 register_bank. Takes one operand-access command per instruction from the decode stage (optional write-back plus up to two operand reads), sequences them over the bank's toggle-trigger interface (addr, rw, data_in, trigger, data_out), and returns both read operands through a valid/ready response port. It is the driving end of the bank protocol that the register-bank bench currently exercises by hand.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 4, register address width (16 registers)
- SETTLE_CYCLES, 4, clk cycles between a trigger toggle and bank completion; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_wr_en  in  1  perform write-back
- cmd_wr_addr  in  ADDR_W  write register
- cmd_wr_data  in  DATA_W  write value
- cmd_rd_a_en / cmd_rd_b_en  in  1  perform read A / read B
- cmd_rd_a_addr / cmd_rd_b_addr  in  ADDR_W  read registers
- rsp_valid  out  1  response held until taken
- rsp_ready  in  1  consumer takes response
- rsp_a / rsp_b  out  DATA_W  read results; 0 for a disabled read
- bank_addr  out  ADDR_W  to register_bank addr
- bank_rw  out  1  to register_bank rw; 1 = read, 0 = write
- bank_data_in  out  DATA_W  to register_bank data_in
- bank_trigger  out  1  to register_bank trigger; each toggle (either edge) starts one access
- bank_data_out  in  DATA_W  from register_bank data_out

## Operation
- States: IDLE, SETUP, WAIT, RESP.
- cmd_ready = (state == IDLE) & !rsp_valid. All command fields are registered at acceptance; later cmd_* changes are ignored.
- Access order within a command: write (if cmd_wr_en), then read A, then read B; disabled accesses are skipped. Write-first is mandatory: a read of the register just written returns the new value.
- SETUP (1 cycle): bank_addr, bank_rw, bank_data_in are already driven from the accept/previous-sample edge; at the end of SETUP, bank_trigger toggles.
- WAIT: a 4-bit counter runs SETTLE_CYCLES cycles after the toggle. For reads, bank_data_out is captured into rsp_a/rsp_b at the final WAIT edge. At the same edge, the next access's addr/rw/data are driven and the FSM returns to SETUP. With no accesses left, rsp_valid is asserted and the FSM goes to RESP.
- Command with no enables: no bank activity; go directly to RESP with rsp_a = rsp_b = 0.
- RESP: rsp_valid, rsp_a, and rsp_b are held stable until rsp_valid & rsp_ready, then the FSM returns to IDLE. cmd_ready goes high the following cycle (no same-cycle accept).
- bank_addr, bank_rw, and bank_data_in hold their values between accesses and while idle. bank_rw returns to 1 after each write's WAIT ends. bank_data_in keeps the last written value.
- Disabled-read result registers are cleared to 0 at acceptance.

## Timing
- Reset (async assert, sync release) values: cmd_ready 1, rsp_valid 0, rsp_a 0, rsp_b 0, bank_addr 0, bank_rw 1, bank_data_in 0, bank_trigger 0, state IDLE, counter 0.
- Reset mid-access: if bank_trigger was 1, forcing it to 0 is itself a toggle. Because bank_rw is forced to 1 at the same instant, the bank sees a harmless read and no write is ever issued by reset. An in-flight command is discarded and no response is produced.
- Accept at edge E0 → first toggle at E1 → sample at E1+SETTLE_CYCLES.
- Each access costs 1+SETTLE_CYCLES cycles.
- N accesses (1..3) → rsp_valid rises at E0 + N*(1+SETTLE_CYCLES). N = 0 → rsp_valid rises at E0+1.
- Default SETTLE_CYCLES = 4, full command (N = 3): rsp_valid at E0+15.
- Exactly one bank_trigger toggle per enabled access.
- bank_addr, bank_rw, and bank_data_in never change during SETUP or WAIT.
- Throughput: minimum 1 idle cycle between response take and next accept.

## Test plan
- Reset, then read A = R1 and read B = R2 with the bank preloaded R1 = 0, R2 = 1 → two trigger toggles at E0+1 and E0+6, bank_rw = 1 throughout, rsp_valid at E0+10, rsp_a = 0, rsp_b = 1, bank_rw = 1.
- Write R8 = 8, then read A = R8, read B disabled → first toggle with bank_rw = 0, bank_addr = 8, bank_data_in = 8; second toggle with bank_rw = 1; rsp_a = 8, rsp_b = 0 at E0+10.
- Full command (write R3 = 0xDEADBEEF, read A = R3, read B = R0) with rsp_ready held low 20 cycles → rsp_valid at E0+15; response stable until taken; cmd_ready stays 0 until the cycle after the take.
- No-enable command → no bank_trigger activity; rsp_valid at E0+1 with both results 0.
- Assert rst_n low during the WAIT of a write's first access (bank_trigger = 1) → all outputs go to reset values immediately, bank_rw = 1 when trigger falls, no rsp_valid; a subsequent read returns the bank's true contents.
- SETTLE_CYCLES = 1, back-to-back commands with rsp_ready tied high → per-access spacing of 2 cycles; every command answered once, in order, with correct data.
